// File: rtl/tt_add_accum.sv
// Registered add/sub/accumulate unit with a one-deep valid/ready output stage.
// The accumulator persists across transactions; LOAD seeds it and clears the sticky overflow.
module tt_add_accum #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 carry,
  output logic                 overflow_sticky,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int AW1 = ACC_WIDTH + 1;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] sum);
    if (SATURATE != 0 && sum[ACC_WIDTH])
      return '1;
    else
      return sum[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic                 vld_p1;
  logic [ACC_WIDTH-1:0] result_p1;
  logic                 carry_p1;
  logic [ACC_WIDTH-1:0] acc_p1;
  logic                 sticky_p1;
  logic [CNT_WIDTH-1:0] cnt_p1;

  logic                 accept;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     sub_diff;
  logic [ACC_WIDTH-1:0] load_val;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] nxt_result;
  logic                 nxt_carry;
  logic [ACC_WIDTH-1:0] nxt_acc;
  logic                 nxt_sticky;

  assign in_ready        = !vld_p1 || out_ready;
  assign accept          = in_valid && in_ready;
  assign out_valid       = vld_p1;
  assign result          = result_p1;
  assign carry           = carry_p1;
  assign overflow_sticky = sticky_p1;
  assign count           = cnt_p1;

  // Stage p0: operand arithmetic, evaluated every cycle and used only on accept
  always_comb begin
    add_sum    = {1'b0, op_a} + {1'b0, op_b};
    sub_diff   = op_a - op_b;
    load_val   = ACC_WIDTH'(op_a) + ACC_WIDTH'(op_b);
    acc_sum    = {1'b0, acc_p1} + AW1'(op_a) + AW1'(op_b);
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_acc    = acc_p1;
    nxt_sticky = sticky_p1;
    case (mode)
      MODE_ADD: begin
        nxt_result = ACC_WIDTH'(add_sum);
        nxt_carry  = add_sum[WIDTH];
      end
      MODE_SUB: begin
        nxt_result = ACC_WIDTH'(sub_diff);
        nxt_carry  = (op_b > op_a);
      end
      MODE_LOAD: begin
        nxt_acc    = load_val;
        nxt_result = load_val;
        nxt_sticky = 1'b0;
      end
      MODE_ACC: begin
        nxt_acc    = sat_acc(acc_sum);
        nxt_result = sat_acc(acc_sum);
        nxt_carry  = acc_sum[ACC_WIDTH];
        nxt_sticky = sticky_p1 | acc_sum[ACC_WIDTH];
      end
    endcase
  end

  // Stage p1: output register; a new accept overwrites it even while the old result drains
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      carry_p1  <= 1'b0;
      acc_p1    <= '0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      result_p1 <= nxt_result;
      carry_p1  <= nxt_carry;
      acc_p1    <= nxt_acc;
      sticky_p1 <= nxt_sticky;
      cnt_p1    <= sat_inc(cnt_p1);
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

endmodule
